servo_pwm_gen: RTL and testbench



---
 rtl/servo_pwm_gen.sv | 99 +++++++++
 tb/tb_servo_pwm_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - hobby-servo PWM generator with per-frame angle sampling and slew limit
module servo_pwm_gen #(
    parameter int PERIOD_CYCLES  = 500000,
    parameter int MIN_PULSE      = 25000,
    parameter int CYCLES_PER_DEG = 69,
    parameter int STEP_DEG       = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [8:0] i_Angle,
    output logic       o_Servo_PWM,
    output logic       o_Period_Start,
    output logic [8:0] o_Cur_Angle,
    output logic       o_At_Target
);

    localparam int CW = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0] LAST    = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] MIN_P   = CW'(MIN_PULSE);
    localparam logic [CW-1:0] CPD     = CW'(CYCLES_PER_DEG);
    localparam logic [8:0]    STEP    = 9'(STEP_DEG);
    localparam logic [8:0]    MAX_ANG = 9'd360;

    typedef enum logic {GAP = 1'b0, PULSE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pulse_len_q, pulse_len_d;
    logic [8:0]    cur_q, cur_d;
    logic          at_q, at_d;
    logic          ps_q, ps_d;

    logic [8:0]    target;
    logic [8:0]    cur_next;
    logic [8:0]    diff_up;
    logic [8:0]    diff_dn;
    logic [CW-1:0] cnt_inc;
    logic          frame_start;

    always_comb begin
        target   = (i_Angle > MAX_ANG) ? MAX_ANG : i_Angle;
        diff_up  = target - cur_q;
        diff_dn  = cur_q - target;
        cur_next = target;
        if (STEP_DEG != 0) begin
            if (target > cur_q) begin
                cur_next = (diff_up > STEP) ? cur_q + STEP : target;
            end else if (target < cur_q) begin
                cur_next = (diff_dn > STEP) ? cur_q - STEP : target;
            end
        end
    end

    // The pulse stays high while the post-increment count is still inside pulse_len.
    always_comb begin
        frame_start = (cnt_q == LAST);
        cnt_inc     = cnt_q + ONE;
        cnt_d       = cnt_inc;
        state_d     = (cnt_inc < pulse_len_q) ? PULSE : GAP;
        pulse_len_d = pulse_len_q;
        cur_d       = cur_q;
        at_d        = at_q;
        ps_d        = 1'b0;
        if (frame_start) begin
            cnt_d       = '0;
            state_d     = PULSE;
            cur_d       = cur_next;
            pulse_len_d = MIN_P + CW'(cur_next) * CPD;
            at_d        = (cur_next == target);
            ps_d        = 1'b1;
        end
    end

    // Counter resets to the last slot so the first edge out of reset opens a frame.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q     <= GAP;
            cnt_q       <= LAST;
            pulse_len_q <= MIN_P;
            cur_q       <= '0;
            at_q        <= 1'b0;
            ps_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_len_q <= pulse_len_d;
            cur_q       <= cur_d;
            at_q        <= at_d;
            ps_q        <= ps_d;
        end
    end

    assign o_Servo_PWM    = (state_q == PULSE);
    assign o_Period_Start = ps_q;
    assign o_Cur_Angle    = cur_q;
    assign o_At_Target    = at_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - scoreboard bench for servo_pwm_gen (unlimited and 45-degree slew instances)
module tb_servo_pwm_gen;

    localparam int PERIOD = 1000;

    logic       clk;
    logic       rst_n [2];
    logic [8:0] angle [2];
    logic       pwm   [2];
    logic       ps    [2];
    logic [8:0] cur   [2];
    logic       at    [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int pulse;
        int cur;
        int at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e_mon;

    int hi    [2];
    int flen  [2];
    int epul  [2];
    bit hf    [2];
    bit ev    [2];
    bit prev  [2];

    servo_pwm_gen #(
        .PERIOD_CYCLES(PERIOD), .MIN_PULSE(100), .CYCLES_PER_DEG(2), .STEP_DEG(0)
    ) u_fast (
        .i_Clk(clk), .i_Rst_n(rst_n[0]), .i_Angle(angle[0]),
        .o_Servo_PWM(pwm[0]), .o_Period_Start(ps[0]),
        .o_Cur_Angle(cur[0]), .o_At_Target(at[0])
    );

    servo_pwm_gen #(
        .PERIOD_CYCLES(PERIOD), .MIN_PULSE(100), .CYCLES_PER_DEG(2), .STEP_DEG(45)
    ) u_slew (
        .i_Clk(clk), .i_Rst_n(rst_n[1]), .i_Angle(angle[1]),
        .o_Servo_PWM(pwm[1]), .o_Period_Start(ps[1]),
        .o_Cur_Angle(cur[1]), .o_At_Target(at[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int k, input int p, input int c, input int a);
        exp_t e;
        e.pulse = p;
        e.cur   = c;
        e.at    = a;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ps(input int k);
        int n;
        n = 0;
        @(posedge clk);
        @(negedge clk);
        while (!ps[k] && n < PERIOD + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(k == 0 ? "fast_ps_seen" : "slew_ps_seen", int'(ps[k]), 1);
    endtask

    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                hf[k]   = 1'b0;
                ev[k]   = 1'b0;
                prev[k] = 1'b0;
            end else begin
                if (ps[k]) begin
                    if (hf[k]) check_eq(k == 0 ? "fast_period" : "slew_period", flen[k], PERIOD);
                    hf[k]   = 1'b1;
                    flen[k] = 1;
                    hi[k]   = int'(pwm[k]);
                    ev[k]   = 1'b0;
                    if (k == 0 && q0.size() > 0) begin
                        e_mon = q0.pop_front();
                        ev[k] = 1'b1;
                    end else if (k == 1 && q1.size() > 0) begin
                        e_mon = q1.pop_front();
                        ev[k] = 1'b1;
                    end
                    if (ev[k]) begin
                        check_eq(k == 0 ? "fast_cur" : "slew_cur", int'(cur[k]), e_mon.cur);
                        check_eq(k == 0 ? "fast_at" : "slew_at", int'(at[k]), e_mon.at);
                        epul[k] = e_mon.pulse;
                    end
                end else begin
                    flen[k]++;
                    if (pwm[k]) hi[k]++;
                    if (prev[k] && !pwm[k] && ev[k]) begin
                        check_eq(k == 0 ? "fast_pulse" : "slew_pulse", hi[k], epul[k]);
                        ev[k] = 1'b0;
                    end
                end
                prev[k] = pwm[k];
            end
        end
    end

    task automatic run_fast();
        push_exp(0, 280, 90, 1);
        wait_ps(0);
        angle[0] = 9'd400;
        push_exp(0, 820, 360, 1);
        wait_ps(0);
        angle[0] = 9'd0;
        push_exp(0, 100, 0, 1);
        wait_ps(0);
        angle[0] = 9'd90;
        push_exp(0, 280, 90, 1);
        wait_ps(0);
        repeat (150) @(negedge clk);
        angle[0] = 9'd270;
        push_exp(0, 640, 270, 1);
        wait_ps(0);
        angle[0] = 9'd90;
        push_exp(0, 280, 90, 1);
        wait_ps(0);
        repeat (50) @(negedge clk);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_pwm", int'(pwm[0]), 0);
        check_eq("midrst_cur", int'(cur[0]), 0);
        check_eq("midrst_ps", int'(ps[0]), 0);
        check_eq("midrst_at", int'(at[0]), 0);
        push_exp(0, 280, 90, 1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("restart_ps", int'(ps[0]), 1);
        check_eq("restart_pwm", int'(pwm[0]), 1);
        wait_ps(0);
    endtask

    task automatic run_slew();
        angle[1] = 9'd180;
        push_exp(1, 190, 45, 0);
        wait_ps(1);
        push_exp(1, 280, 90, 0);
        wait_ps(1);
        push_exp(1, 370, 135, 0);
        wait_ps(1);
        push_exp(1, 460, 180, 1);
        wait_ps(1);
        angle[1] = 9'd160;
        push_exp(1, 420, 160, 1);
        wait_ps(1);
        angle[1] = 9'd0;
        push_exp(1, 330, 115, 0);
        wait_ps(1);
        wait_ps(1);
    endtask

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        angle[0] = 9'd90;
        angle[1] = 9'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_pwm", int'(pwm[0]), 0);
            check_eq("rst_ps", int'(ps[0]), 0);
            check_eq("rst_cur", int'(cur[0]), 0);
            check_eq("rst_at", int'(at[0]), 0);
            check_eq("rst_pwm_slew", int'(pwm[1]), 0);
        end
        push_exp(0, 280, 90, 1);
        push_exp(1, 100, 0, 1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("first_ps", int'(ps[0]), 1);
        check_eq("first_pwm", int'(pwm[0]), 1);
        check_eq("first_ps_slew", int'(ps[1]), 1);
        fork
            run_fast();
            run_slew();
        join
        check_eq("sb_empty", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
